// File: rtl/temporal_neuron.sv
// Temporal neuron: integrates weighted step-no-leak spike responses over one gamma cycle and
// reports the first threshold crossing. Optional LATERAL_INHIBIT_EN adds a sticky inhibit input.
module temporal_neuron #(
  parameter int unsigned NUM_INPUTS  = 8,
  parameter int unsigned WEIGHT_W    = 3,
  parameter int unsigned POT_W       = 8,
  parameter int unsigned TIME_PERIOD = 8,
  localparam int unsigned TW = (TIME_PERIOD > 1) ? $clog2(TIME_PERIOD) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           in_valid,
`ifdef LATERAL_INHIBIT_EN
  input  logic                           inhibit,
`endif
  input  logic [NUM_INPUTS-1:0]          spike_in,
  input  logic [NUM_INPUTS*WEIGHT_W-1:0] weights,
  input  logic [POT_W-1:0]               threshold,
  output logic                           busy,
  output logic                           out_spike,
  output logic                           out_valid,
  output logic                           fired,
  output logic [TW-1:0]                  out_time,
  output logic [POT_W-1:0]               potential
);

  localparam int unsigned SumW = WEIGHT_W + $clog2(NUM_INPUTS + 1);
  localparam int unsigned AccW = ((SumW > POT_W) ? SumW : POT_W) + 1;
  localparam logic [POT_W-1:0] PotMax = {POT_W{1'b1}};
  localparam logic [TW-1:0] LastStep = TW'(TIME_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StIntegrate, StDone} state_e;

  state_e                  state_q, state_d;
  logic [POT_W-1:0]        pot_q, pot_d;
  logic [NUM_INPUTS-1:0]   mask_q, mask_d;
  logic [TW-1:0]           step_q, step_d;
  logic [POT_W-1:0]        thr_q, thr_d;
  logic                    fired_q, fired_d;
  logic [TW-1:0]           fire_time_q, fire_time_d;
  logic                    spike_q, spike_d;
  logic                    frozen;

  logic [NUM_INPUTS-1:0]   mask_n;
  logic [SumW-1:0]         inc;
  logic [AccW-1:0]         acc;
  logic [POT_W-1:0]        pot_n;

  // Step response: every input seen so far (including this step) contributes its weight.
  always_comb begin
    mask_n = mask_q | spike_in;
    inc    = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (mask_n[i]) inc = inc + SumW'(weights[i*WEIGHT_W +: WEIGHT_W]);
    end
    acc   = AccW'(pot_q) + AccW'(inc);
    pot_n = (acc > AccW'(PotMax)) ? PotMax : acc[POT_W-1:0];
  end

`ifdef LATERAL_INHIBIT_EN
  logic inhib_q, inhib_d;
  // Inhibition only bites before the neuron has fired.
  assign frozen = !fired_q && (inhib_q || inhibit);
`else
  assign frozen = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pot_d       = pot_q;
    mask_d      = mask_q;
    step_d      = step_q;
    thr_d       = thr_q;
    fired_d     = fired_q;
    fire_time_d = fire_time_q;
    spike_d     = 1'b0;
`ifdef LATERAL_INHIBIT_EN
    inhib_d     = inhib_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StIntegrate;
          pot_d       = '0;
          mask_d      = '0;
          step_d      = '0;
          fired_d     = 1'b0;
          fire_time_d = '0;
          thr_d       = threshold;
`ifdef LATERAL_INHIBIT_EN
          inhib_d     = 1'b0;
`endif
        end
      end
      StIntegrate: begin
        if (in_valid) begin
          mask_d = mask_n;
          if (!frozen) begin
            pot_d = pot_n;
            if (!fired_q && (pot_n >= thr_q)) begin
              fired_d     = 1'b1;
              fire_time_d = step_q;
              spike_d     = 1'b1;
            end
          end
`ifdef LATERAL_INHIBIT_EN
          inhib_d = inhib_q | frozen;
`endif
          if (step_q == LastStep) begin
            state_d = StDone;
          end else begin
            step_d = step_q + TW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pot_q       <= '0;
      mask_q      <= '0;
      step_q      <= '0;
      thr_q       <= '0;
      fired_q     <= 1'b0;
      fire_time_q <= '0;
      spike_q     <= 1'b0;
`ifdef LATERAL_INHIBIT_EN
      inhib_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pot_q       <= pot_d;
      mask_q      <= mask_d;
      step_q      <= step_d;
      thr_q       <= thr_d;
      fired_q     <= fired_d;
      fire_time_q <= fire_time_d;
      spike_q     <= spike_d;
`ifdef LATERAL_INHIBIT_EN
      inhib_q     <= inhib_d;
`endif
    end
  end

  assign busy      = (state_q == StIntegrate);
  assign out_valid = (state_q == StDone);
  assign out_spike = spike_q;
  assign fired     = fired_q;
  assign out_time  = fired_q ? fire_time_q : LastStep;
  assign potential = pot_q;

endmodule

// File: tb/tb_temporal_neuron.sv
// Scoreboard bench for temporal_neuron: directed gamma cycles push expectations, a negedge
// monitor checks each out_valid result, the out_spike timing and the cycle latency.
module tb_temporal_neuron;
  localparam int unsigned N  = 8;
  localparam int unsigned WW = 3;
  localparam int unsigned PW = 8;
  localparam int unsigned TP = 8;
  localparam int unsigned TW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  spike_in = '0;
  logic [N*WW-1:0] weights = '0;
  logic [PW-1:0] threshold = '0;
`ifdef LATERAL_INHIBIT_EN
  logic          inhibit = 1'b0;
`endif
  logic          busy, out_spike, out_valid, fired;
  logic [TW-1:0] out_time;
  logic [PW-1:0] potential;

  temporal_neuron #(
    .NUM_INPUTS (N),
    .WEIGHT_W   (WW),
    .POT_W      (PW),
    .TIME_PERIOD(TP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
`ifdef LATERAL_INHIBIT_EN
    .inhibit  (inhibit),
`endif
    .spike_in (spike_in),
    .weights  (weights),
    .threshold(threshold),
    .busy     (busy),
    .out_spike(out_spike),
    .out_valid(out_valid),
    .fired    (fired),
    .out_time (out_time),
    .potential(potential)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fired;
    int   t;
    int   pot;
    int   lat;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: inputs are stable at the negedge, so a busy&&in_valid negedge is a consumed step.
  int   mon_step = 0;
  int   last_step = -1;
  int   spk_cnt = 0;
  int   spk_time = -1;
  int   cyc = 0;
  exp_t cur;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_step = 0; last_step = -1; spk_cnt = 0; spk_time = -1; cyc = 0;
      end else begin
        if (out_spike) begin
          spk_cnt++;
          spk_time = last_step;
        end
        if (busy) cyc++;
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got out_valid=1, expected no result pending");
          end else begin
            cur = exp_q.pop_front();
            check("fired", int'(fired), int'(cur.fired));
            check("out_time", int'(out_time), cur.t);
            check("potential", int'(potential), cur.pot);
            check("out_spike_count", spk_cnt, cur.fired ? 1 : 0);
            check("latency", cyc, cur.lat);
            if (cur.fired) check("out_spike_step", spk_time, cur.t);
          end
          mon_step = 0; last_step = -1; spk_cnt = 0; spk_time = -1; cyc = 0;
        end
        if (busy && in_valid) begin
          last_step = mon_step;
          mon_step++;
        end
      end
    end
  end

  // One gamma cycle. sp_step<0 means spike 'mask' every step; stall cycles precede step stall_at.
  task automatic run(input int thr, input logic [N*WW-1:0] w, input logic [N-1:0] mask,
                     input int sp_step, input int stall_at, input int stall_len,
                     input int inh_step, input logic efired, input int et, input int epot,
                     input bit start_in_done);
    exp_t e;
    e.fired = efired;
    e.t     = et;
    e.pot   = epot;
    e.lat   = TP + ((stall_at >= 0) ? stall_len : 0);
    @(posedge clk); #1;
    threshold = PW'(thr);
    weights   = w;
    start     = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    for (int s = 0; s < TP; s++) begin
      if (s == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          in_valid = 1'b0;
          spike_in = '1;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      spike_in = (sp_step < 0 || s == sp_step) ? mask : '0;
`ifdef LATERAL_INHIBIT_EN
      inhibit  = (s == inh_step);
`endif
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    spike_in = '0;
`ifdef LATERAL_INHIBIT_EN
    inhibit  = 1'b0;
`endif
    start = start_in_done;
    @(posedge clk); #1;
    if (start_in_done) check("start_in_done_ignored", int'(busy), 0);
    start = 1'b0;
    check("result_consumed", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_potential", int'(potential), 0);
    check("rst_out_time", int'(out_time), TP - 1);
    rst = 1'b0;

    // Reset during step 3 aborts the cycle cleanly.
    @(posedge clk); #1;
    threshold = 8'd10;
    weights   = {N{3'd2}};
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      in_valid = 1'b1;
      spike_in = (s == 1) ? 8'h01 : 8'h00;
      @(posedge clk); #1;
    end
    spike_in = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_potential", int'(potential), 0);
    check("midrst_out_time", int'(out_time), TP - 1);
    check("midrst_fired", int'(fired), 0);
    check("midrst_out_valid", int'(out_valid), 0);

    // thr, weights, mask, sp_step, stall_at, stall_len, inh, fired, time, pot, start_in_done
    run(10, {N{3'd2}}, 8'h01, 1, -1, 0, -1, 1'b1, 5, 14, 1'b0);
    run(200, {18'd0, 3'd1, 3'd1}, 8'h03, 0, -1, 0, -1, 1'b0, 7, 16, 1'b0);
    run(255, {N{3'd7}}, 8'hFF, -1, -1, 0, -1, 1'b1, 4, 255, 1'b0);
    run(10, {N{3'd2}}, 8'h01, 1, 3, 3, -1, 1'b1, 5, 14, 1'b0);
    run(0, {N{3'd5}}, 8'h00, -1, -1, 0, -1, 1'b1, 0, 0, 1'b0);
    run(16, {N{3'd2}}, 8'h01, 0, -1, 0, -1, 1'b1, 7, 16, 1'b1);
`ifdef LATERAL_INHIBIT_EN
    run(10, {N{3'd2}}, 8'h01, 1, -1, 0, 3, 1'b0, 7, 4, 1'b0);
    run(10, {N{3'd2}}, 8'h01, 1, -1, 0, 6, 1'b1, 5, 14, 1'b0);
    run(10, {N{3'd2}}, 8'h01, 1, -1, 0, 5, 1'b0, 7, 8, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
